// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch input front end.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } btn_state_t;

  localparam int unsigned CLK_HZ                  = 100000000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_LONG_CYCLES     = 200000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_sync_chain.sv
// N-flop synchroniser with asynchronous active-low reset to 0.
module sync_chain #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain_q;
  logic [N-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain_q <= '0;
    else          chain_q <= chain_d;
  end

  assign q = chain_q[N-1];

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: synchroniser, 4-state debounce FSM, edge pulses, toggle latch.
// Optional long-press strobe enabled by defining BTN_LONG_PRESS_EN.
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic toggle_clr,
  output logic level_q,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic toggle_q,
  output logic long_pulse
);

  localparam int unsigned CNT_MAX = max_u(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

  logic s;

  sync_chain #(.N(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (s)
  );

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, rise_q, rise_d, fall_q, fall_d, toggle_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      STABLE_LOW: if (s) begin
        state_d = WAIT_HIGH;
        cnt_d   = CNT_W'(1);
      end
      WAIT_HIGH: if (!s) begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end else if (cnt_q == DEB_LAST) begin
        state_d = STABLE_HIGH;
        cnt_d   = '0;
        level_d = 1'b1;
        rise_d  = 1'b1;
      end else if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      STABLE_HIGH: if (!s) begin
        state_d = WAIT_LOW;
        cnt_d   = CNT_W'(1);
      end
      WAIT_LOW: if (s) begin
        state_d = STABLE_HIGH;
        cnt_d   = '0;
      end else if (cnt_q == DEB_LAST) begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
        fall_d  = 1'b1;
      end else if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // Clear beats a rise in the same cycle.
    if (toggle_clr)  toggle_d = 1'b0;
    else if (rise_q) toggle_d = ~toggle_q;
    else             toggle_d = toggle_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold count runs only in STABLE_HIGH, freezes across a WAIT_LOW bounce,
  // and is cleared on entry from WAIT_HIGH or on any return to the low side.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == STABLE_HIGH) begin
      if (hold_q == LONG_LAST) long_d = 1'b1;
      if (hold_q != LONG_SAT)  hold_d = hold_q + CNT_W'(1);
    end else if (state_q == WAIT_HIGH || state_d == STABLE_LOW) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic reset_n, btn_raw, toggle_clr;
  logic level_q, rise_pulse, fall_pulse, toggle_q, long_pulse;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned rises, falls, rise_edge;

  btn_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .toggle_clr (toggle_clr),
    .level_q    (level_q),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .toggle_q   (toggle_q),
    .long_pulse (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count pulses over n edges from now; record the first rise edge index.
  task automatic watch(input int unsigned n);
    rises = 0; falls = 0; rise_edge = 999;
    for (int unsigned i = 0; i < n; i++) begin
      step(1);
      if (rise_pulse) begin
        if (rises == 0) rise_edge = i;
        rises++;
      end
      if (fall_pulse) falls++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; btn_raw = 1'b0; toggle_clr = 1'b0;
    step(3);
    chk("rst_level",  level_q,    1'b0);
    chk("rst_rise",   rise_pulse, 1'b0);
    chk("rst_fall",   fall_pulse, 1'b0);
    chk("rst_toggle", toggle_q,   1'b0);
    chk("rst_long",   long_pulse, 1'b0);
    reset_n = 1'b1;
    step(3);

    // Clean press: next posedge is edge 0.
    btn_raw = 1'b1;
    step(5);
    chk("press_e4_level", level_q, 1'b0);
    chk("press_e4_rise",  rise_pulse, 1'b0);
    step(1);
    chk("press_e5_level", level_q, 1'b1);
    chk("press_e5_rise",  rise_pulse, 1'b1);
    chk("press_e5_toggle", toggle_q, 1'b0);
    step(1);
    chk("press_e6_rise",   rise_pulse, 1'b0);
    chk("press_e6_toggle", toggle_q, 1'b1);

    // Long press: commit at edge 5, strobe visible after edge 15 only with the feature.
    step(8);
    chk("long_e14", long_pulse, 1'b0);
    step(1);
`ifdef BTN_LONG_PRESS_EN
    chk("long_e15", long_pulse, 1'b1);
`else
    chk("long_e15", long_pulse, 1'b0);
`endif
    step(1);
    chk("long_e16", long_pulse, 1'b0);
    rises = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      step(1);
      if (long_pulse) rises++;
    end
    chk_n("long_once", rises, 0);

    // Release.
    btn_raw = 1'b0;
    step(5);
    chk("rel_e4_level", level_q, 1'b1);
    chk("rel_e4_fall",  fall_pulse, 1'b0);
    step(1);
    chk("rel_e5_level", level_q, 1'b0);
    chk("rel_e5_fall",  fall_pulse, 1'b1);
    chk("rel_e5_rise",  rise_pulse, 1'b0);
    step(1);
    chk("rel_e6_fall",   fall_pulse, 1'b0);
    chk("rel_e6_toggle", toggle_q, 1'b1);

    // Bounce: 3-cycle glitch rejected.
    btn_raw = 1'b1;
    step(3);
    btn_raw = 1'b0;
    watch(8);
    chk_n("glitch_rises", rises, 0);
    chk("glitch_level", level_q, 1'b0);
    btn_raw = 1'b1;
    watch(7);
    chk_n("bounce_rise_count", rises, 1);
    chk_n("bounce_rise_edge", rise_edge, 5);
    chk("bounce_toggle", toggle_q, 1'b0);
    btn_raw = 1'b0;
    watch(8);
    chk_n("bounce_rel_falls", falls, 1);
    chk("bounce_rel_level", level_q, 1'b0);

    // Third press with toggle_clr in the rise cycle.
    btn_raw = 1'b1;
    step(6);
    chk("clr_rise", rise_pulse, 1'b1);
    toggle_clr = 1'b1;
    step(1);
    toggle_clr = 1'b0;
    chk("clr_toggle", toggle_q, 1'b0);
    btn_raw = 1'b0;
    step(8);

    // Reset mid WAIT_HIGH (cnt=2 after edge 3), input held high through release.
    btn_raw = 1'b1;
    step(4);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_level", level_q, 1'b0);
    chk("mid_rst_rise",  rise_pulse, 1'b0);
    watch(3);
    chk_n("mid_rst_norise", rises, 0);
    reset_n = 1'b1;
    watch(7);
    chk_n("rel_rst_rise_count", rises, 1);
    chk_n("rel_rst_rise_edge", rise_edge, 5);
    chk("rel_rst_level", level_q, 1'b1);
    chk("rel_rst_toggle", toggle_q, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Per-button input front end for the stopwatch; one instance per raw push button or slider switch.
- Synchronises the raw input to `clk` and debounces it with a 4-state FSM.
- Produces a stable level, one-cycle rise/fall pulses, and a toggle latch (for example, the paused/running state driven by the pause button).
- Feeds the counter and mode-select logic downstream.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops; legal values 2..4.
- DEBOUNCE_CYCLES, 1000000: consecutive cycles the synchronised input must hold before a level change commits (10 ms at 100 MHz); must be ≥ 2.
- LONG_CYCLES, 200000000: hold time, in cycles after a rise commit, before long_pulse fires (2 s at 100 MHz); used only with the optional feature.

Ports:
- clk  input  1  system clock (100 MHz master)
- reset_n  input  1  asynchronous active-low reset
- btn_raw  input  1  raw, asynchronous, bouncing button/switch input
- toggle_clr  input  1  synchronous clear of toggle_q; must be synchronous to clk
- level_q  output  1  debounced level
- rise_pulse  output  1  one-cycle strobe when level_q goes 0→1
- fall_pulse  output  1  one-cycle strobe when level_q goes 1→0
- toggle_q  output  1  flips on every rise_pulse
- long_pulse  output  1  one-cycle long-press strobe (tied 0 without the feature)

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-edge release):
  - sync flops = 0, FSM = STABLE_LOW, counters = 0.
  - level_q = 0, rise_pulse = 0, fall_pulse = 0, toggle_q = 0, long_pulse = 0.
- Synchroniser: a SYNC_STAGES-deep chain on btn_raw; its last stage is `s`. The FSM sees only `s`.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- STABLE_LOW:
  - s=1 → WAIT_HIGH with cnt=1.
  - Otherwise stay.
- WAIT_HIGH:
  - s=0 → STABLE_LOW, cnt=0 (glitch rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 → STABLE_HIGH; register level_q=1 and rise_pulse=1 on the same edge.
  - Otherwise cnt+1.
- STABLE_HIGH and WAIT_LOW mirror the two states above with polarity inverted; the commit sets level_q=0 and fall_pulse=1.
- Latency: commit happens on the edge where the FSM has sampled s at its new value for DEBOUNCE_CYCLES consecutive edges.
  - Example, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, btn_raw rising before edge 0 and held: s=1 after edge 1; level_q/rise_pulse high after edge 5.
  - Total: SYNC_STAGES+DEBOUNCE_CYCLES-1 edges.
- Pulses are exactly one cycle wide and never both high in the same cycle. Minimum spacing between opposite pulses is DEBOUNCE_CYCLES cycles.
- cnt width is clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1). cnt saturates and never wraps.
- toggle_q:
  - toggle_clr=1 → toggle_q=0 next edge.
  - Else rise_pulse=1 → toggle_q inverts.
  - toggle_clr wins over a simultaneous rise_pulse.
- Reset asserted mid-debounce: the in-progress WAIT is discarded and no pulse is emitted. After release, a held-high input must requalify through the full latency.
- btn_raw already stable high at reset release: treated as a fresh press, so rise_pulse fires after the full latency.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- Defined:
  - In STABLE_HIGH a hold counter starts at 0 on entry.
  - When it reaches LONG_CYCLES-1, long_pulse fires for one cycle, then the counter saturates.
  - At most one long_pulse per press. Leaving STABLE_HIGH (including via WAIT_LOW→STABLE_LOW) resets the counter.
  - A WAIT_LOW that returns to STABLE_HIGH does not reset the hold counter.
- Undefined: long_pulse is constant 0, the hold counter and its logic are absent, and LONG_CYCLES is ignored.

Decomposition:
- stopwatch_pkg:
  - btn_state_t enum (STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW).
  - DEFAULT_DEBOUNCE_CYCLES, DEFAULT_LONG_CYCLES, DEFAULT_SYNC_STAGES.
  - CLK_HZ = 100000000.
- One sub-module: sync_chain (parameterised N-flop synchroniser, async active-low reset to 0), reusable for the slider switches.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10):
- Reset then clean press: btn_raw 0→1 before edge 0, held → level_q=1 and rise_pulse high for exactly the cycle after edge 5; toggle_q=1 after edge 6.
- Bounce rejection: btn_raw pulses high for 3 cycles, low, then high again and held → no rise_pulse for the 3-cycle glitch; a single rise_pulse 5 edges after the final rise.
- Release: after a committed press, btn_raw→0 → fall_pulse one cycle, level_q=0 at the same latency; toggle_q unchanged.
- Toggle and clear: two clean presses → toggle_q 1 then 0. Asserting toggle_clr in the rise_pulse cycle of a third press → toggle_q=0.
- Reset mid-operation: reset_n low during WAIT_HIGH (cnt=2) → all outputs 0, no pulse. Release with btn_raw held high → rise_pulse after the full latency.
- BTN_LONG_PRESS_EN: hold 20 cycles past the commit → exactly one long_pulse, 10 cycles after the commit edge. Without the macro → long_pulse stays 0.
